// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter for one memory channel. Read owners are kept in an
// in-order tag queue so that returning read responses can be steered back to their requester.
module mem_req_arbiter #(
    parameter int unsigned LOG_OUTSTANDING = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    // Request layout: {valid, isWrite, addr[63:0], data[511:0]}
    input  logic [1:0][577:0] req_in,
    output logic [1:0]        req_grant_out,
    // Response layout: {valid, data[511:0]}
    output logic [1:0][512:0] resp_out,
    input  logic [1:0]        resp_grant_in,
    output logic [577:0]      mem_req_out,
    input  logic              mem_req_grant_in,
    input  logic [512:0]      mem_resp_in,
    output logic              mem_resp_grant_out,
    output logic [LOG_OUTSTANDING:0] outstanding_out,
    output logic              err_out
);

    localparam int unsigned PtrW  = LOG_OUTSTANDING;
    localparam int unsigned CntW  = LOG_OUTSTANDING + 1;
    localparam int unsigned Depth = 1 << LOG_OUTSTANDING;

    localparam int unsigned ReqValidBit = 577;
    localparam int unsigned ReqWriteBit = 576;
    localparam int unsigned RespValidBit = 512;

    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic             prio_q, prio_d;
    logic [Depth-1:0] queue_q;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             err_q, err_d;

    logic       full;
    logic       empty;
    logic [1:0] elig;
    logic       sel;
    logic       sel_valid;
    logic       xfer;
    logic       push;
    logic       pop;
    logic       owner;
    logic       resp_valid;
    logic       orphan;

    // Request selection. Full is judged on the registered count, so a same-cycle pop
    // never lets a read slip in.
    always_comb begin
        full  = (count_q == CntFull);
        empty = (count_q == '0);
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_in[i][ReqValidBit] & (req_in[i][ReqWriteBit] | ~full);
        end
        sel       = (elig[0] & elig[1]) ? prio_q : elig[1];
        sel_valid = rst_n & (|elig);

        mem_req_out   = sel_valid ? req_in[sel] : '0;
        xfer          = sel_valid & mem_req_grant_in;
        req_grant_out = {xfer & sel, xfer & ~sel};
        push          = xfer & ~req_in[sel][ReqWriteBit];
    end

    // Response routing to the owner at the head of the tag queue.
    always_comb begin
        resp_valid         = rst_n & mem_resp_in[RespValidBit];
        owner              = queue_q[rd_ptr_q];
        resp_out           = '0;
        mem_resp_grant_out = 1'b0;
        pop                = 1'b0;
        orphan             = 1'b0;
        if (resp_valid) begin
            if (empty) begin
                mem_resp_grant_out = 1'b1;
                orphan             = 1'b1;
            end else begin
                resp_out[owner]    = mem_resp_in;
                mem_resp_grant_out = resp_grant_in[owner];
                pop                = resp_grant_in[owner];
            end
        end
    end

    always_comb begin
        prio_d   = xfer ? ~sel : prio_q;
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (pop && !push) begin
            count_d = count_q - CntOne;
        end
        err_d = err_q | orphan;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q   <= 1'b0;
            queue_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            if (push) begin
                queue_q[wr_ptr_q] <= sel;
            end
        end
    end

    assign outstanding_out = count_q;
    assign err_out         = err_q;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one simplified memory channel (MemReq/MemResp, as presented by DramInterleaver's input side) between two requesters, e.g. the PCIe loopback engine and a second DMA engine.
- Arbitrates requests round-robin.
- Records the owner of every granted read in an in-order tag queue, and steers each returned read response back to that owner.
- Writes produce no response and are not tracked.

Parameters:
- LOG_OUTSTANDING, 3, log2 of the maximum number of outstanding reads (tag queue depth = 8).

Ports:
- clk  in  1  user clock
- rst_n  in  1  asynchronous active-low reset
- req_in[1:0]  in  $bits(MemReq) each  per-requester request {valid, isWrite, addr[63:0], data[511:0]}
- req_grant_out[1:0]  out  1 each  request accepted this cycle
- resp_out[1:0]  out  $bits(MemResp) each  per-requester read response {valid, data[511:0]}
- resp_grant_in[1:0]  in  1 each  requester consumes response
- mem_req_out  out  $bits(MemReq)  to memory channel
- mem_req_grant_in  in  1  channel accepts request
- mem_resp_in  in  $bits(MemResp)  from memory channel
- mem_resp_grant_out  out  1  response consumed
- outstanding_out  out  LOG_OUTSTANDING+1  reads in flight
- err_out  out  1  sticky: response arrived with an empty tag queue

Behaviour:
- Handshake: valid/grant, same cycle, as used throughout the codebase.
  - A requester holds valid and a stable payload until its grant.
  - req_grant_out[i] = mem_req_grant_in AND (i is the selected requester).
- Selection (combinational):
  - Eligible = valid AND (isWrite OR tag queue not full).
  - If both are eligible, pick the one pointed to by prio.
  - Otherwise pick the single eligible requester.
  - If none is eligible, mem_req_out.valid = 0.
  - mem_req_out is the selected payload unmodified.
  - With no selection, mem_req_out is all zeros.
- prio register (1 bit):
  - Resets to 0.
  - On any granted transfer from requester i, prio <= ~i.
  - Otherwise holds.
- Tag queue:
  - Circular buffer of 2^LOG_OUTSTANDING 1-bit owner IDs, with wr_ptr, rd_ptr and count.
  - Push the owner on a granted read (isWrite = 0).
  - Pop on a completed response handshake.
- Full rule: when count = 2^LOG_OUTSTANDING, reads are not eligible, even if a pop occurs in the same cycle. Writes still proceed.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Pointer wrap is modulo 2^LOG_OUTSTANDING.
- outstanding_out = count.
- Response routing (combinational):
  - If mem_resp_in.valid and the queue is non-empty, owner o = queue[rd_ptr].
  - resp_out[o] = mem_resp_in; resp_out[~o].valid = 0 with data 0.
  - mem_resp_grant_out = resp_grant_in[o].
  - Pop when mem_resp_in.valid AND resp_grant_in[o].
  - Responses return in request order; the block does no reordering.
- Orphan response (mem_resp_in.valid with count = 0):
  - mem_resp_grant_out = 1 (the response is drained and dropped).
  - Both resp_out are invalid.
  - err_out <= 1.
- Backpressure: a stalled owner (resp_grant_in[o] = 0) blocks responses only. Requests continue until the queue is full.
- Latency: zero-cycle request path and zero-cycle response path. The only state is prio, the queue, and err.
- Reset (asynchronous assert, any cycle including mid-transfer):
  - prio = 0, wr_ptr = rd_ptr = count = 0, err_out = 0, queue contents = 0.
  - While rst_n = 0, every grant, mem_req_out.valid, and resp_out[*].valid is forced to 0.
  - Reads in flight across a reset are lost. Their later responses are treated as orphans (dropped, err_out set).
- Arithmetic: count is LOG_OUTSTANDING+1 bits and never exceeds 2^LOG_OUTSTANDING. Pointers are LOG_OUTSTANDING bits.

Test Plan:
- Contention fairness: both requesters issue continuous reads, channel always grants, responses immediate -> grants alternate 0,1,0,1 starting with 0; each requester gets 50 of 100.
- Single requester: only req 1 is valid, issuing a write to addr 0x40 -> granted the same cycle; mem_req_out matches the payload bit-for-bit; prio becomes 0; outstanding_out stays 0.
- In-order routing: reads issued in owner order 0,1,1,0 with data tagged A,B,C,D -> resp_out[0] receives A then D, resp_out[1] receives B then C; outstanding_out returns to 0.
- Full queue: 8 reads granted with no responses -> outstanding_out = 8 and further reads get no grant, while a write from the other requester is granted. A response with a read pending in the same cycle -> no read grant that cycle; the read is granted the next cycle.
- Backpressure: response owned by req 0 while resp_grant_in[0] = 0 for 5 cycles -> mem_resp_grant_out = 0 for 5 cycles, resp_out[1].valid stays 0, count unchanged; pop occurs on the first cycle of grant.
- Reset mid-flight: 3 reads outstanding, assert rst_n low for 2 cycles -> outputs go invalid immediately and count = 0. A later response -> dropped with grant = 1 and err_out = 1, held until the next reset.
